// File: rtl/alu_seq.sv
// alu_seq: parametrised sequential ALU with iterative shifts and shift-add multiply
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : request handshake, op accepted when both high on an edge
//   a, b, sel             : operands and opcode, captured at acceptance
//   out_valid             : one-cycle pulse qualifying f / ovf / take_branch
//   f, ovf, take_branch   : registered result, overflow flag, branch decision
module alu_seq #(
   parameter int WIDTH = 16,
   parameter int SW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       sel,
   output logic             out_valid,
   output logic [WIDTH-1:0] f,
   output logic             ovf,
   output logic             take_branch
);
   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
   state_t               state_q, state_d;
   logic [WIDTH-1:0]     f_q, f_d, b_q, b_d;
   logic                 ovf_q, ovf_d, br_q, br_d;
   logic [3:0]           sel_q, sel_d;
   logic [SW:0]          cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   work_q, work_d, mcand_q, mcand_d;
   logic [WIDTH-1:0]     sum, diff, r1_f, sh_nx;
   logic [2*WIDTH-1:0]   acc_nx;
   logic [SW-1:0]        k;
   logic                 r1_ovf, r1_br, accept, multi, is_mul;

   assign k        = b[SW-1:0];
   assign sum      = a + b;
   assign diff     = a - b;
   assign accept   = in_valid && in_ready;
   assign multi    = ((sel == 4'd6 || sel == 4'd7) && k != '0) || sel == 4'd11;
   assign is_mul   = sel_q == 4'd11;
   // one bit position per iteration; work_q low half holds the shifting operand
   assign sh_nx    = sel_q == 4'd6 ? {work_q[WIDTH-1], work_q[WIDTH-1:1]} : {work_q[WIDTH-2:0], 1'b0};
   // shift-add: b_q supplies one multiplier bit per cycle, mcand_q doubles each cycle
   assign acc_nx   = work_q + (b_q[0] ? mcand_q : '0);
   assign in_ready = state_q != EXEC;
   assign out_valid = state_q == DONE;
   assign f        = f_q;
   assign ovf      = ovf_q;
   assign take_branch = br_q;

   // single-cycle results; shifts only reach here with k=0, so f=a
   always_comb begin
      r1_f   = '0;
      r1_ovf = 1'b0;
      r1_br  = 1'b0;
      case (sel)
         4'd0: begin
            r1_f   = sum;
            r1_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         4'd1: begin
            r1_f   = diff;
            r1_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         4'd2:       r1_f  = ~b;
         4'd3:       r1_f  = a & b;
         4'd4:       r1_f  = a | b;
         4'd5:       r1_f  = a ^ b;
         4'd6, 4'd7: r1_f  = a;
         4'd8:       r1_br = a == b;
         4'd9:       r1_br = a != b;
         4'd10:      r1_br = $signed(a) < $signed(b);
         default:    ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      f_d     = f_q;
      ovf_d   = ovf_q;
      br_d    = br_q;
      b_d     = b_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
      mcand_d = mcand_q;
      if (state_q == EXEC) begin
         work_d  = is_mul ? acc_nx : {{WIDTH{1'b0}}, sh_nx};
         mcand_d = mcand_q << 1;
         b_d     = b_q >> 1;
         cnt_d   = cnt_q - 1'b1;
         if (cnt_q == (SW+1)'(1)) begin
            state_d = DONE;
            f_d     = is_mul ? acc_nx[WIDTH-1:0] : sh_nx;
            ovf_d   = is_mul && |acc_nx[2*WIDTH-1:WIDTH];
            br_d    = 1'b0;
         end
      end else if (accept) begin
         sel_d = sel;
         b_d   = b;
         if (multi) begin
            state_d = EXEC;
            cnt_d   = sel == 4'd11 ? (SW+1)'(WIDTH) : {1'b0, k};
            work_d  = sel == 4'd11 ? '0 : {{WIDTH{1'b0}}, a};
            mcand_d = {{WIDTH{1'b0}}, a};
         end else begin
            state_d = DONE;
            f_d     = r1_f;
            ovf_d   = r1_ovf;
            br_d    = r1_br;
         end
      end else begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         f_q     <= '0;
         ovf_q   <= 1'b0;
         br_q    <= 1'b0;
         b_q     <= '0;
         sel_q   <= '0;
         cnt_q   <= '0;
         work_q  <= '0;
         mcand_q <= '0;
      end else begin
         state_q <= state_d;
         f_q     <= f_d;
         ovf_q   <= ovf_d;
         br_q    <= br_d;
         b_q     <= b_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
         mcand_q <= mcand_d;
      end
   end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential ALU, successor to the 8-bit combinational ALU. It adds configurable width, subtract/XOR, signed-less-than branch, barrel-amount shifts and unsigned multiply. Multi-bit shifts and multiply run iteratively over several cycles behind a valid/ready handshake. It sits between the register-file read stage and write-back/branch logic; results are registered and qualified by a one-cycle `out_valid` pulse.

## Interface
- `WIDTH`, default 16: operand and result width; ≥ 4, power of two.
- `SW`, default `$clog2(WIDTH)`: shift-amount width; derived, not overridden.

Ports:
- `clk`, in, 1: rising-edge clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: operation request.
- `in_ready`, out, 1: block can accept; an op is accepted on an edge where `in_valid & in_ready`.
- `a`, in, WIDTH: operand A.
- `b`, in, WIDTH: operand B; for shifts, `b[SW-1:0]` is the amount.
- `sel`, in, 4: opcode.
- `out_valid`, out, 1: result pulse, high exactly one cycle per accepted op.
- `f`, out, WIDTH: registered result.
- `ovf`, out, 1: registered overflow flag.
- `take_branch`, out, 1: registered branch decision.

## Operation
- **Capture:** `a`, `b` and `sel` are latched at the accepting edge. Later input changes are ignored until the next acceptance.
- **Opcodes:**
  - 0 ADD: f=a+b; ovf = signed overflow, i.e. a[MSB]==b[MSB] and f[MSB]!=a[MSB].
  - 1 SUB: f=a-b; ovf = a[MSB]!=b[MSB] and f[MSB]!=a[MSB].
  - 2 NOT: f=~b.
  - 3 AND, 4 OR, 5 XOR: bitwise.
  - 6 SRA: arithmetic right shift of a by k=b[SW-1:0].
  - 7 SLL: logical left shift of a by k.
  - 8 BEQ: take_branch = a==b.
  - 9 BNE: take_branch = a!=b.
  - 10 BLT: take_branch = signed a < signed b.
  - 11 MUL: unsigned shift-add. f = low WIDTH bits of the product; ovf=1 iff the high WIDTH bits are nonzero.
  - 12–15: reserved. f=0, ovf=0, take_branch=0; completes as a 1-cycle op.
- **Flag rules:**
  - ovf is 0 for every op except ADD, SUB and MUL.
  - take_branch is 0 for every op except 8–10.
  - f=0 for branch ops.
- **Iteration counts:**
  - SRA/SLL: n=k iterations, one bit position per cycle. If k=0, the op is 1-cycle and f=a.
  - MUL: n=WIDTH iterations, one multiplier bit per cycle. Accumulator is 2·WIDTH bits.
  - All other ops: n=0.
- **FSM states IDLE, EXEC, DONE:**
  - IDLE: on accept, n=0 → compute and register result, go to DONE; n>0 → load iteration counter, go to EXEC.
  - EXEC: one iteration per edge. On the n-th edge, register f/ovf/take_branch and go to DONE.
  - DONE: `out_valid`=1. If `in_valid`, accept a new op (same transitions as IDLE); otherwise go to IDLE.
- `in_ready` = state != EXEC. Acceptance in DONE gives back-to-back 1-cycle ops at full throughput.
- `f`, `ovf` and `take_branch` hold their value until the next result is registered. They are meaningful only while `out_valid` is high.
- No output backpressure. The consumer must capture results on the `out_valid` pulse.

## Timing
- **Reset (async assert, sync-safe deassert):**
  - state=IDLE, f=0, ovf=0, take_branch=0, out_valid=0.
  - in_ready=1 while in reset and after reset.
- **Latency:** with acceptance at edge E0, `out_valid` is high in cycle n+1 after E0.
  - 1-cycle ops: the cycle immediately after E0.
  - SRA/SLL: k+1 cycles.
  - MUL: WIDTH+1 cycles.
- `in_ready` is low for cycles 1..n after acceptance of a multi-cycle op.
- **Reset mid-EXEC:** the op is abandoned, no `out_valid` is issued, and outputs return to reset values.
- **Shift amount:** k is WIDTH-1 maximum, so SRA of a negative operand by WIDTH-1 gives all ones. Bits of b above SW are ignored.
- **Arithmetic:** ADD/SUB wrap modulo 2^WIDTH. Unsigned carry is not reported.

## Test plan
All cases use WIDTH=16.
- ADD 0x7FFF+0x0001 → f=0x8000, ovf=1, out_valid in cycle 1. SUB 0x8000-0x0001 → f=0x7FFF, ovf=1.
- SRA a=0x8000, b=4 → f=0xF800. in_ready low for cycles 1–4, out_valid in cycle 5. SLL a=0x0001, b=0 → f=0x0001 in cycle 1.
- MUL 3×5 → f=0x000F, ovf=0. MUL 0x0100×0x0100 → f=0x0000, ovf=1. out_valid in cycle 17 for both.
- BLT a=0xFFFF, b=0x0001 → take_branch=1, f=0. BEQ a=b=0x1234 → take_branch=1. BNE on the same operands → 0.
- Back-to-back: AND, OR, XOR issued with in_valid held high → one accept per cycle, out_valid high three consecutive cycles, correct f each cycle.
- Assert rst_n=0 during cycle 8 of a MUL → out_valid never pulses for it, all outputs 0, in_ready=1. A following ADD completes normally.
